// File: rtl/stream_buffer_prefetcher.sv
// rtl/stream_buffer_prefetcher.sv - fill-side controller for the cache stream buffer
module stream_buffer_prefetcher #(
    parameter int BLOCK_ADDR_WIDTH = 30,
    parameter int WIDTH            = 128,
    parameter int DEPTH            = 4,
    parameter int T                = 1
) (
    input  logic                        CLK,
    input  logic                        RESETN,
    input  logic                        ENB,
    input  logic                        MISS_VALID,
    input  logic [BLOCK_ADDR_WIDTH-1:0] MISS_BLOCK_ADDR,
    input  logic                        POP,
    output logic [BLOCK_ADDR_WIDTH-1:0] HEAD_ADDR,
    output logic                        HEAD_VALID,
    output logic [BLOCK_ADDR_WIDTH-1:0] ADDR_TO_MEM,
    output logic                        ADDR_VALID,
    input  logic                        ADDR_READY,
    input  logic [WIDTH-1:0]            DATA_FROM_MEM,
    input  logic                        DATA_VALID,
    output logic                        SB_FLUSH,
    output logic                        SB_WR_ENB,
    output logic [WIDTH-1:0]            SB_DATA_IN,
    output logic                        SB_RD_ENB
);

    localparam int FW = $clog2(DEPTH + 1);
    localparam logic [FW-1:0] DEPTH_F = FW'(DEPTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_FLUSH   = 2'd1;
    localparam logic [1:0] S_REQUEST = 2'd2;
    localparam logic [1:0] S_RECEIVE = 2'd3;

    logic [1:0]                  state_q, state_d;
    logic [BLOCK_ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
    logic [BLOCK_ADDR_WIDTH-1:0] head_addr_q, head_addr_d;
    logic [FW-1:0]               filled_q, filled_d;
    logic [T-1:0]                sec_cnt_q, sec_cnt_d;
    logic                        drop_q, drop_d;

    logic sb_flush, sb_wr_enb, sb_rd_enb, addr_valid;
    logic pop_ok, blk_done;

    always_comb begin
        state_d     = state_q;
        next_addr_d = next_addr_q;
        head_addr_d = head_addr_q;
        filled_d    = filled_q;
        sec_cnt_d   = sec_cnt_q;
        drop_d      = drop_q;
        sb_flush    = 1'b0;
        sb_wr_enb   = 1'b0;
        sb_rd_enb   = 1'b0;
        addr_valid  = 1'b0;
        pop_ok      = 1'b0;
        blk_done    = 1'b0;

        if (ENB) begin
            pop_ok = POP && (filled_q != '0) && (state_q != S_FLUSH);
            case (state_q)
                S_IDLE: begin
                    if (MISS_VALID) begin
                        next_addr_d = MISS_BLOCK_ADDR + BLOCK_ADDR_WIDTH'(1);
                        state_d     = S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    sb_flush    = 1'b1;
                    head_addr_d = next_addr_q;
                    sec_cnt_d   = '0;
                    drop_d      = 1'b0;
                    state_d     = S_REQUEST;
                    if (MISS_VALID) begin
                        next_addr_d = MISS_BLOCK_ADDR + BLOCK_ADDR_WIDTH'(1);
                        state_d     = S_FLUSH;
                    end
                end
                S_REQUEST: begin
                    // A miss withdraws the request in the same cycle so no handshake can slip through.
                    if (MISS_VALID) begin
                        next_addr_d = MISS_BLOCK_ADDR + BLOCK_ADDR_WIDTH'(1);
                        state_d     = S_FLUSH;
                    end else begin
                        addr_valid = (filled_q < DEPTH_F);
                        if (addr_valid && ADDR_READY) begin
                            next_addr_d = next_addr_q + BLOCK_ADDR_WIDTH'(1);
                            state_d     = S_RECEIVE;
                        end
                    end
                end
                default: begin
                    if (MISS_VALID) begin
                        next_addr_d = MISS_BLOCK_ADDR + BLOCK_ADDR_WIDTH'(1);
                        drop_d      = 1'b1;
                    end
                    if (DATA_VALID) begin
                        sb_wr_enb = !drop_q;
                        sec_cnt_d = sec_cnt_q + T'(1);
                        if (sec_cnt_q == {T{1'b1}}) begin
                            blk_done = !drop_q;
                            drop_d   = 1'b0;
                            state_d  = (drop_q || MISS_VALID) ? S_FLUSH : S_REQUEST;
                        end
                    end
                end
            endcase

            sb_rd_enb = pop_ok;
            if (pop_ok) begin
                head_addr_d = head_addr_q + BLOCK_ADDR_WIDTH'(1);
            end
            if (state_q == S_FLUSH) begin
                filled_d = '0;
            end else begin
                filled_d = filled_q + FW'(blk_done) - FW'(pop_ok);
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q     <= S_IDLE;
            next_addr_q <= '0;
            head_addr_q <= '0;
            filled_q    <= '0;
            sec_cnt_q   <= '0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            next_addr_q <= next_addr_d;
            head_addr_q <= head_addr_d;
            filled_q    <= filled_d;
            sec_cnt_q   <= sec_cnt_d;
            drop_q      <= drop_d;
        end
    end

    assign HEAD_ADDR   = head_addr_q;
    assign HEAD_VALID  = (filled_q != '0);
    assign ADDR_TO_MEM = next_addr_q;
    assign ADDR_VALID  = addr_valid;
    assign SB_FLUSH    = sb_flush;
    assign SB_WR_ENB   = sb_wr_enb;
    assign SB_DATA_IN  = DATA_FROM_MEM;
    assign SB_RD_ENB   = sb_rd_enb;

endmodule

// File: tb/tb_stream_buffer_prefetcher.sv
// tb/tb_stream_buffer_prefetcher.sv - directed vector bench for stream_buffer_prefetcher
module tb_stream_buffer_prefetcher;

    logic         CLK = 1'b0;
    logic         RESETN = 1'b0;
    logic         ENB = 1'b0;
    logic         MISS_VALID = 1'b0;
    logic [29:0]  MISS_BLOCK_ADDR = '0;
    logic         POP = 1'b0;
    logic [29:0]  HEAD_ADDR;
    logic         HEAD_VALID;
    logic [29:0]  ADDR_TO_MEM;
    logic         ADDR_VALID;
    logic         ADDR_READY = 1'b0;
    logic [127:0] DATA_FROM_MEM = '0;
    logic         DATA_VALID = 1'b0;
    logic         SB_FLUSH;
    logic         SB_WR_ENB;
    logic [127:0] SB_DATA_IN;
    logic         SB_RD_ENB;

    stream_buffer_prefetcher #(
        .BLOCK_ADDR_WIDTH(30), .WIDTH(128), .DEPTH(4), .T(1)
    ) dut (
        .CLK(CLK), .RESETN(RESETN), .ENB(ENB),
        .MISS_VALID(MISS_VALID), .MISS_BLOCK_ADDR(MISS_BLOCK_ADDR), .POP(POP),
        .HEAD_ADDR(HEAD_ADDR), .HEAD_VALID(HEAD_VALID),
        .ADDR_TO_MEM(ADDR_TO_MEM), .ADDR_VALID(ADDR_VALID), .ADDR_READY(ADDR_READY),
        .DATA_FROM_MEM(DATA_FROM_MEM), .DATA_VALID(DATA_VALID),
        .SB_FLUSH(SB_FLUSH), .SB_WR_ENB(SB_WR_ENB), .SB_DATA_IN(SB_DATA_IN),
        .SB_RD_ENB(SB_RD_ENB)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic         en, miss, pop, rdy, dv;
        logic [29:0]  maddr;
        logic [127:0] data;
        logic         fl, wr, rd, av, hv;
        logic [29:0]  aa, ha;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t tbl[$];

    function automatic vec_t mk(input logic en, miss, input logic [29:0] maddr,
                                input logic pop, rdy, dv, input int k,
                                input logic fl, wr, rd, av, input logic [29:0] aa,
                                input logic hv, input logic [29:0] ha);
        vec_t v;
        v.en = en; v.miss = miss; v.maddr = maddr; v.pop = pop; v.rdy = rdy; v.dv = dv;
        v.data = {4{32'hA5A5_0000 + 32'(k)}};
        v.fl = fl; v.wr = wr; v.rd = rd; v.av = av; v.aa = aa; v.hv = hv; v.ha = ha;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_row(input vec_t v, input string tag);
        @(negedge CLK);
        ENB = v.en; MISS_VALID = v.miss; MISS_BLOCK_ADDR = v.maddr; POP = v.pop;
        ADDR_READY = v.rdy; DATA_VALID = v.dv; DATA_FROM_MEM = v.data;
        #1;
        chk({tag, "_flush"}, 128'(SB_FLUSH), 128'(v.fl));
        chk({tag, "_wr"}, 128'(SB_WR_ENB), 128'(v.wr));
        chk({tag, "_rd"}, 128'(SB_RD_ENB), 128'(v.rd));
        chk({tag, "_avalid"}, 128'(ADDR_VALID), 128'(v.av));
        chk({tag, "_hvalid"}, 128'(HEAD_VALID), 128'(v.hv));
        chk({tag, "_haddr"}, 128'(HEAD_ADDR), 128'(v.ha));
        if (v.av) chk({tag, "_aaddr"}, 128'(ADDR_TO_MEM), 128'(v.aa));
        if (v.wr) chk({tag, "_wdata"}, SB_DATA_IN, v.data);
    endtask

    initial begin
        // reset held 3 cycles with a stray data strobe
        for (int i = 0; i < 3; i++)
            run_row(mk(1,0,0, 0,1,1,i, 0,0,0,0,0, 0,0), $sformatf("rst%0d", i));
        RESETN = 1'b1;
        run_row(mk(1,0,0, 0,0,1,9, 0,0,0,0,0, 0,0), "idle_dv");

        // miss 0x100, fill to full, pop, then re-miss mid-block
        tbl.push_back(mk(1,1,30'h100, 0,0,0,0,  0,0,0,0,0,       0,30'h000));
        tbl.push_back(mk(1,0,0,       0,0,0,0,  1,0,0,0,0,       0,30'h000));
        tbl.push_back(mk(1,0,0,       0,1,0,0,  0,0,0,1,30'h101, 0,30'h101));
        tbl.push_back(mk(1,0,0,       0,0,0,0,  0,0,0,0,0,       0,30'h101));
        tbl.push_back(mk(1,0,0,       0,0,1,1,  0,1,0,0,0,       0,30'h101));
        tbl.push_back(mk(1,0,0,       0,0,1,2,  0,1,0,0,0,       0,30'h101));
        tbl.push_back(mk(1,0,0,       0,1,0,0,  0,0,0,1,30'h102, 1,30'h101));
        tbl.push_back(mk(1,0,0,       0,0,0,0,  0,0,0,0,0,       1,30'h101));
        tbl.push_back(mk(1,0,0,       0,0,1,3,  0,1,0,0,0,       1,30'h101));
        tbl.push_back(mk(1,0,0,       0,0,1,4,  0,1,0,0,0,       1,30'h101));
        tbl.push_back(mk(1,0,0,       0,1,0,0,  0,0,0,1,30'h103, 1,30'h101));
        tbl.push_back(mk(1,0,0,       0,0,0,0,  0,0,0,0,0,       1,30'h101));
        tbl.push_back(mk(1,0,0,       0,0,1,5,  0,1,0,0,0,       1,30'h101));
        tbl.push_back(mk(1,0,0,       0,0,1,6,  0,1,0,0,0,       1,30'h101));
        tbl.push_back(mk(1,0,0,       0,1,0,0,  0,0,0,1,30'h104, 1,30'h101));
        tbl.push_back(mk(1,0,0,       0,0,0,0,  0,0,0,0,0,       1,30'h101));
        tbl.push_back(mk(1,0,0,       0,0,1,7,  0,1,0,0,0,       1,30'h101));
        tbl.push_back(mk(1,0,0,       0,0,1,8,  0,1,0,0,0,       1,30'h101));
        tbl.push_back(mk(1,0,0,       0,1,0,0,  0,0,0,0,0,       1,30'h101));
        tbl.push_back(mk(1,0,0,       0,1,0,0,  0,0,0,0,0,       1,30'h101));
        tbl.push_back(mk(1,0,0,       1,1,0,0,  0,0,1,0,0,       1,30'h101));
        tbl.push_back(mk(1,0,0,       0,1,0,0,  0,0,0,1,30'h105, 1,30'h102));
        tbl.push_back(mk(1,0,0,       0,0,0,0,  0,0,0,0,0,       1,30'h102));
        tbl.push_back(mk(1,0,0,       0,0,1,10, 0,1,0,0,0,       1,30'h102));
        tbl.push_back(mk(1,1,30'h200, 0,0,0,0,  0,0,0,0,0,       1,30'h102));
        tbl.push_back(mk(1,0,0,       0,0,1,11, 0,0,0,0,0,       1,30'h102));
        tbl.push_back(mk(1,0,0,       0,0,0,0,  1,0,0,0,0,       1,30'h102));
        tbl.push_back(mk(1,0,0,       0,1,0,0,  0,0,0,1,30'h201, 0,30'h201));
        foreach (tbl[i]) run_row(tbl[i], $sformatf("row%0d", i));

        // asynchronous reset while receiving
        run_row(mk(1,0,0, 0,0,0,0, 0,0,0,0,0, 0,30'h201), "pre_rst");
        RESETN = 1'b0;
        run_row(mk(1,0,0, 0,1,1,12, 0,0,0,0,0, 0,0), "mid_rst");
        RESETN = 1'b1;

        // all-ones miss wraps to 0, pop on last section, ENB low mid-block
        run_row(mk(1,1,30'h3FFF_FFFF, 0,0,0,0, 0,0,0,0,0,    0,30'h0), "w0");
        run_row(mk(1,0,0, 0,0,0,0,  1,0,0,0,0,    0,30'h0), "w1");
        run_row(mk(1,0,0, 0,1,0,0,  0,0,0,1,30'h0, 0,30'h0), "w2");
        run_row(mk(1,0,0, 0,0,0,0,  0,0,0,0,0,    0,30'h0), "w3");
        run_row(mk(1,0,0, 0,0,1,20, 0,1,0,0,0,    0,30'h0), "w4");
        run_row(mk(1,0,0, 0,0,1,21, 0,1,0,0,0,    0,30'h0), "w5");
        run_row(mk(1,0,0, 0,1,0,0,  0,0,0,1,30'h1, 1,30'h0), "w6");
        run_row(mk(1,0,0, 0,0,0,0,  0,0,0,0,0,    1,30'h0), "w7");
        run_row(mk(1,0,0, 0,0,1,22, 0,1,0,0,0,    1,30'h0), "w8");
        run_row(mk(1,0,0, 1,0,1,23, 0,1,1,0,0,    1,30'h0), "w9_pop_last");
        run_row(mk(1,0,0, 0,1,0,0,  0,0,0,1,30'h2, 1,30'h1), "w10");
        run_row(mk(1,0,0, 0,0,1,24, 0,1,0,0,0,    1,30'h1), "w11");
        for (int i = 0; i < 5; i++)
            run_row(mk(0,0,0, 1,1,1,30+i, 0,0,0,0,0, 1,30'h1), $sformatf("enb_low%0d", i));
        run_row(mk(1,0,0, 0,0,1,25, 0,1,0,0,0,    1,30'h1), "w_resume");
        run_row(mk(1,0,0, 0,1,0,0,  0,0,0,1,30'h3, 1,30'h1), "w_next_req");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stream_buffer_prefetcher.md
Name: stream_buffer_prefetcher

Overview:
- Fill-side controller for the instruction/data cache stream buffer.
- On a cache miss to block A, it flushes the stream buffer and fetches blocks A+1, A+2, … from the lower memory level.
- It writes each returned section into the buffer in order, with 2^T sections per block.
- It exposes the head-block address and valid flag so the cache can check a hit and pop the block.

Parameters:
- BLOCK_ADDR_WIDTH, 30, width of a cache-block address.
- WIDTH, 128, width of one section on the memory return bus and the buffer write port.
- DEPTH, 4, number of blocks the stream buffer holds; power of two.
- T, 1, 2^T sections per block.

Ports:
- CLK  in  1  clock, rising edge.
- RESETN  in  1  asynchronous active-low reset.
- ENB  in  1  global enable; when low, all state is frozen and strobes are driven to 0.
- MISS_VALID  in  1  one-cycle miss notification from the cache.
- MISS_BLOCK_ADDR  in  BLOCK_ADDR_WIDTH  missed block address.
- POP  in  1  the cache has consumed the head block.
- HEAD_ADDR  out  BLOCK_ADDR_WIDTH  block address of the buffer head.
- HEAD_VALID  out  1  the head block is completely written into the buffer.
- ADDR_TO_MEM  out  BLOCK_ADDR_WIDTH  prefetch request address.
- ADDR_VALID  out  1  request valid.
- ADDR_READY  in  1  memory accepts the request.
- DATA_FROM_MEM  in  WIDTH  returned section.
- DATA_VALID  in  1  section valid; sections of a request arrive in order, at most one per cycle.
- SB_FLUSH  out  1  synchronous clear pulse to the buffer reset.
- SB_WR_ENB  out  1  buffer write strobe.
- SB_DATA_IN  out  WIDTH  buffer write data.
- SB_RD_ENB  out  1  buffer block-advance strobe.

Behaviour:
- Reset (RESETN low): all outputs and registers are 0 and the state is IDLE.
- Internal registers:
  - next_addr: address of the next block to request.
  - head_addr: drives HEAD_ADDR.
  - filled: 0..DEPTH, number of complete blocks in the buffer.
  - sec_cnt: T bits, current section within the block being received.
  - drop: set while a stale in-flight block is being discarded.
- HEAD_VALID = (filled != 0). SB_DATA_IN = DATA_FROM_MEM (combinational).
- State machine IDLE / FLUSH / REQUEST / RECEIVE:
  - IDLE: on MISS_VALID, latch next_addr = MISS_BLOCK_ADDR+1 and go to FLUSH.
  - FLUSH (exactly 1 cycle):
    - SB_FLUSH=1.
    - head_addr <= next_addr; filled <= 0; sec_cnt <= 0.
    - Go to REQUEST.
  - REQUEST:
    - ADDR_VALID = (filled < DEPTH) and ADDR_TO_MEM = next_addr.
    - On ADDR_VALID & ADDR_READY: next_addr++ and go to RECEIVE.
    - ADDR_VALID must stay high with a stable address until ADDR_READY.
  - RECEIVE:
    - On each DATA_VALID: SB_WR_ENB = !drop and sec_cnt++.
    - On the last section (sec_cnt == 2^T-1): if !drop, filled++; then go to REQUEST, or go to FLUSH if drop was set (drop is cleared).
- Miss handling by state:
  - Miss during REQUEST: latch MISS+1 and go to FLUSH. Any un-accepted request is withdrawn; withdrawal is legal only because ADDR_READY was not seen.
  - Miss during RECEIVE: latch MISS+1 and set drop. The remaining sections of the in-flight block are consumed without writing, then the FSM goes to FLUSH.
  - Miss during FLUSH: re-latch the new address and stay in FLUSH one more cycle.
- POP handling:
  - When POP & HEAD_VALID and the state is not FLUSH: SB_RD_ENB=1 the same cycle, head_addr++, filled--.
  - POP with HEAD_VALID=0, or during FLUSH, is ignored.
- POP on the same cycle as a block completing: filled is unchanged and head_addr advances.
- Address arithmetic wraps modulo 2^BLOCK_ADDR_WIDTH; all-ones + 1 = 0.
- Buffer never overflows: a new request is issued only when filled < DEPTH, and at most one block is in flight.
- Latency: MISS at cycle n → SB_FLUSH at n+1 → ADDR_VALID with A+1 at n+2.
- ENB low: no state change; SB_FLUSH, SB_WR_ENB, SB_RD_ENB and ADDR_VALID are all 0; DATA_VALID is ignored.
- RESETN asserted mid-RECEIVE aborts immediately. The memory side is reset in the same domain.

Test Plan:
- Reset with RESETN low for 3 cycles → all outputs 0 and HEAD_VALID=0. A DATA_VALID pulse → no SB_WR_ENB.
- MISS_VALID with addr 0x100, ADDR_READY tied high, each request answered by 2 sections 2 cycles later → SB_FLUSH at n+1; requests 0x101, 0x102, 0x103, 0x104; 8 writes in order; HEAD_ADDR=0x101; HEAD_VALID after the 2nd section; ADDR_VALID stays low once filled=4.
- From the full state, POP once → SB_RD_ENB pulse, HEAD_ADDR=0x102, filled 3; the next cycle requests 0x105.
- New miss 0x200 after the first section of an in-flight block → the second section is not written; SB_FLUSH is issued after it; the next request is 0x201.
- MISS_BLOCK_ADDR all-ones → the first request is 0x0, then 0x1.
- POP coincident with the last section of block 2 (filled=1 beforehand) → filled stays 1 and HEAD_ADDR advances by 1. ENB low for 5 cycles mid-RECEIVE → no writes, and receiving resumes correctly afterwards.
